// File: rtl/tlk2711_tx_sched.sv
// tlk2711_tx_sched: round-robin frame scheduler driving one TLK2711 transmit port.
module tlk2711_tx_sched #(
  parameter int NREQ     = 2,
  parameter int SYNC_LEN = 4,
  parameter int LEN_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_link_up,
  input  logic [NREQ-1:0]       i_req,
  input  logic [NREQ*LEN_W-1:0] i_len,
  input  logic [NREQ*16-1:0]    i_data,
  input  logic [NREQ-1:0]       i_valid,
  output logic [NREQ-1:0]       o_ready,
  output logic [NREQ-1:0]       o_gnt,
  output logic [NREQ-1:0]       o_done,
  output logic                  o_abort,
  output logic                  o_busy,
  output logic [15:0]           o_txd,
  output logic                  o_tkmsb,
  output logic                  o_tklsb
);
  localparam int IW = $clog2(NREQ);
  localparam int SW = $clog2(SYNC_LEN + 1);
  localparam logic [15:0] SP = 16'hC5BC;
  localparam logic [15:0] SF = 16'h5CFB;
  localparam logic [15:0] EF = 16'hFDFE;
  typedef enum logic [2:0] {IDLE, SYNC, SOF, DATA, END, GAP} state_t;
  state_t cs, ns;
  logic [IW-1:0] gidx, gidx_n, rr, rr_n, win;
  logic [LEN_W-1:0] rem, rem_n;
  logic [SW-1:0] scnt, scnt_n;
  logic [NREQ-1:0] gnt_n, done_n;
  logic [15:0] txd_n;
  logic [1:0] tk_n;
  logic abort_n, found;
  assign o_busy  = cs != IDLE;
  assign o_ready = (cs == DATA && i_link_up && rem != '0) ? o_gnt : '0;
  always_comb begin
    ns = cs;
    gnt_n = o_gnt;
    gidx_n = gidx;
    rr_n = rr;
    rem_n = rem;
    scnt_n = scnt;
    txd_n = SP;
    tk_n = 2'b01;
    done_n = '0;
    abort_n = 1'b0;
    found = 1'b0;
    win = '0;
    for (int k = 0; k < NREQ; k++)
      if (!found && i_req[(int'(rr) + k) % NREQ]) begin
        found = 1'b1;
        win = IW'((int'(rr) + k) % NREQ);
      end
    case (cs)
      IDLE: if (i_link_up && found) begin
        ns = SYNC;
        gnt_n = NREQ'(1) << win;
        gidx_n = win;
        rem_n = i_len[int'(win)*LEN_W +: LEN_W];
        scnt_n = '0;
      end
      SYNC: begin
        scnt_n = scnt + 1'b1;
        ns = (scnt == SW'(SYNC_LEN - 1)) ? SOF : SYNC;
      end
      SOF: begin
        txd_n = SF;
        tk_n = 2'b11;
        ns = (rem != '0) ? DATA : END;
      end
      DATA: if (i_valid[gidx]) begin
        txd_n = i_data[int'(gidx)*16 +: 16];
        tk_n = 2'b00;
        rem_n = rem - 1'b1;
        ns = (rem == LEN_W'(1)) ? END : DATA;
      end else begin
        txd_n = EF;
        tk_n = 2'b11;
        abort_n = 1'b1;
        ns = GAP;
      end
      END: begin
        txd_n = EF;
        tk_n = 2'b11;
        done_n = o_gnt;
        ns = GAP;
      end
      GAP: begin
        gnt_n = '0;
        rr_n = (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;
        ns = IDLE;
      end
      default: ns = IDLE;
    endcase
    // Link loss overrides the handshake: close the frame with EF right away
    if (!i_link_up && (cs == SYNC || cs == SOF || cs == DATA)) begin
      txd_n = EF;
      tk_n = 2'b11;
      abort_n = 1'b1;
      rem_n = rem;
      ns = GAP;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cs <= IDLE;
      o_gnt <= '0;
      gidx <= '0;
      rr <= '0;
      rem <= '0;
      scnt <= '0;
      o_txd <= SP;
      {o_tkmsb, o_tklsb} <= 2'b01;
      o_done <= '0;
      o_abort <= 1'b0;
    end else begin
      cs <= ns;
      o_gnt <= gnt_n;
      gidx <= gidx_n;
      rr <= rr_n;
      rem <= rem_n;
      scnt <= scnt_n;
      o_txd <= txd_n;
      {o_tkmsb, o_tklsb} <= tk_n;
      o_done <= done_n;
      o_abort <= abort_n;
    end
  end
endmodule

// File: tb/tb_tlk2711_tx_sched.sv
// tb_tlk2711_tx_sched: directed checks of framing, arbitration, abort and reset.
module tb_tlk2711_tx_sched;
  logic clk = 1'b0, rst = 1'b1, link_up = 1'b0;
  logic [1:0] req = '0, valid = 2'b11;
  logic [31:0] len = '0, data = '0;
  logic [1:0] ready, gnt, done;
  logic abort, busy, tkmsb, tklsb;
  logic [15:0] txd;
  int checks = 0, errors = 0;
  int widx[2];
  tlk2711_tx_sched #(.NREQ(2), .SYNC_LEN(4), .LEN_W(16)) dut (
    .clk(clk), .rst(rst), .i_link_up(link_up), .i_req(req), .i_len(len),
    .i_data(data), .i_valid(valid), .o_ready(ready), .o_gnt(gnt), .o_done(done),
    .o_abort(abort), .o_busy(busy), .o_txd(txd), .o_tkmsb(tkmsb), .o_tklsb(tklsb)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++)
      if (ready[i] && valid[i]) begin
        data[i*16 +: 16] = (i == 0 ? 16'h00A1 : 16'h00B1) + 16'(widx[i]);
        widx[i]++;
      end
  endtask
  task automatic line(input string tag, input logic [15:0] w, input logic [1:0] k);
    chk({tag, "_txd"}, txd, w);
    chk({tag, "_k"}, {tkmsb, tklsb}, k);
  endtask
  int n, gap, bad;
  initial begin
    widx[0] = 0;
    widx[1] = 0;
    repeat (3) step();
    line("rst", 16'hC5BC, 2'b01);
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_abort", abort, 0);
    chk("rst_ready", ready, 0);
    rst = 1'b0;
    link_up = 1'b1;
    step();
    // single request, len 3
    req = 2'b01;
    len[15:0] = 16'd3;
    step();
    chk("s_gnt", gnt, 2'b01);
    chk("s_busy", busy, 1);
    req = 2'b00;
    for (int i = 0; i < 4; i++) begin
      step();
      line("s_sp", 16'hC5BC, 2'b01);
    end
    step();
    line("s_sf", 16'h5CFB, 2'b11);
    for (int i = 0; i < 3; i++) begin
      step();
      line("s_dat", 16'h00A1 + 16'(i), 2'b00);
      chk("s_nodone", done, 0);
    end
    step();
    line("s_ef", 16'hFDFE, 2'b11);
    chk("s_done", done, 2'b01);
    step();
    line("s_gap", 16'hC5BC, 2'b01);
    chk("s_done_clr", done, 0);
    chk("s_gnt_clr", gnt, 0);
    chk("s_idle", busy, 0);
    // zero length on requester 1
    req = 2'b10;
    len[31:16] = 16'd0;
    step();
    chk("z_gnt", gnt, 2'b10);
    req = 2'b00;
    for (int i = 0; i < 4; i++) begin
      step();
      line("z_sp", 16'hC5BC, 2'b01);
    end
    step();
    line("z_sf", 16'h5CFB, 2'b11);
    chk("z_ready", ready, 0);
    step();
    line("z_ef", 16'hFDFE, 2'b11);
    chk("z_done", done, 2'b10);
    step();
    line("z_gap", 16'hC5BC, 2'b01);
    // contention
    req = 2'b11;
    len = {16'd2, 16'd2};
    bad = 0;
    gap = 2;
    for (int f = 0; f < 4; f++) begin
      n = 0;
      while (gnt != 0 && n < 30) begin step(); n++; end
      while (gnt == 0 && n < 30) begin step(); n++; end
      chk("c_gnt", gnt, (f % 2) ? 2'b10 : 2'b01);
      if (f > 0) chk("c_space", n >= 2, 1);
      n = 0;
      while (done == 0 && n < 30) begin
        if (gnt == 2'b11) bad++;
        step();
        n++;
      end
      chk("c_done", done, (f % 2) ? 2'b10 : 2'b01);
      if (f == 3) req = 2'b00;
    end
    chk("c_never11", bad, 0);
    repeat (3) step();
    chk("c_idle", busy, 0);
    // underrun on requester 0 after 2 words
    widx[0] = 0;
    req = 2'b01;
    len[15:0] = 16'd4;
    step();
    chk("u_gnt", gnt, 2'b01);
    repeat (5) step();
    line("u_sf", 16'h5CFB, 2'b11);
    step();
    line("u_d1", 16'h00A1, 2'b00);
    step();
    line("u_d2", 16'h00A2, 2'b00);
    valid[0] = 1'b0;
    step();
    line("u_ef", 16'hFDFE, 2'b11);
    chk("u_abort", abort, 1);
    chk("u_nodone", done, 0);
    req = 2'b11;
    len[31:16] = 16'd0;
    step();
    chk("u_abort_clr", abort, 0);
    chk("u_gnt_clr", gnt, 0);
    step();
    chk("u_next", gnt, 2'b10);
    req = 2'b00;
    valid[0] = 1'b1;
    n = 0;
    while (busy && n < 30) begin step(); n++; end
    chk("u_fin", busy, 0);
    // link drop during SYNC
    req = 2'b01;
    len[15:0] = 16'd5;
    step();
    chk("l_gnt", gnt, 2'b01);
    step();
    link_up = 1'b0;
    step();
    line("l_ef", 16'hFDFE, 2'b11);
    chk("l_abort", abort, 1);
    chk("l_nodone", done, 0);
    step();
    line("l_sp", 16'hC5BC, 2'b01);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("l_hold_busy", busy, 0);
      chk("l_hold_gnt", gnt, 0);
      line("l_hold", 16'hC5BC, 2'b01);
    end
    req = 2'b00;
    link_up = 1'b1;
    step();
    // reset mid-DATA: pointer now favours requester 1
    widx[1] = 0;
    req = 2'b10;
    len[31:16] = 16'd5;
    step();
    chk("r_gnt", gnt, 2'b10);
    repeat (6) step();
    line("r_dat", 16'h00B1, 2'b00);
    rst = 1'b1;
    step();
    rst = 1'b0;
    line("r_sp", 16'hC5BC, 2'b01);
    chk("r_gnt0", gnt, 0);
    chk("r_busy", busy, 0);
    req = 2'b11;
    step();
    chk("r_rr0", gnt, 2'b01);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
